// File: rtl/deser_pkg.sv
// Shared types, default geometry and elaboration helpers for the multilane deserializer.
// Per-instance widths are derived from the module parameters through the helper functions.
package deser_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_VALID = 1'b1
    } outState_t;

    localparam int DATA_SIZE_DEFAULT = 32;
    localparam int LANES_DEFAULT     = 1;
    localparam int BEATS_PER_WORD    = DATA_SIZE_DEFAULT / LANES_DEFAULT;
    localparam int CNT_W             = $clog2(DATA_SIZE_DEFAULT) + 1;

    function automatic int cntWidth(input int dataSize);
        return $clog2(dataSize) + 1;
    endfunction

    function automatic int beatsPerWord(input int dataSize, input int lanes);
        return dataSize / lanes;
    endfunction

    // A word must split into a whole number of beats of a supported lane count.
    function automatic bit geometryOk(input int dataSize, input int lanes);
        return ((lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8)) &&
               (lanes <= dataSize) && ((dataSize % lanes) == 0);
    endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Shift register and bit counter that assemble LANES-wide beats into words.
// oWord/oDone present the completed word combinationally on its final beat.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic                            iEn,
    input  logic                            iLoading,
    input  logic                            iClear,
    input  logic [LANES-1:0]                iData_in,
    output logic [DATA_SIZE-1:0]            oWord,
    output logic                            oDone,
    output logic [cntWidth(DATA_SIZE)-1:0]  oBit_counter
);

    localparam int CNT_WIDTH = cntWidth(DATA_SIZE);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_SIZE - LANES);
    localparam logic [CNT_WIDTH-1:0] CNT_STEP = CNT_WIDTH'(LANES);

    logic [DATA_SIZE-1:0] shreg;
    logic [DATA_SIZE-1:0] assembled;
    logic [CNT_WIDTH-1:0] bitCount;
    logic                 beat;

    assign beat         = iEn && iLoading && !iClear;
    assign oDone        = beat && (bitCount == LAST_CNT);
    assign oWord        = assembled;
    assign oBit_counter = bitCount;

    // Value the shift register would take if this cycle carries a beat.
    always_comb begin
        assembled = shreg;
        if (MSB_FIRST) begin
            assembled = (shreg << LANES) | DATA_SIZE'(iData_in);
        end else begin
            assembled[bitCount +: LANES] = iData_in;
        end
    end

    // A completed word is handed off, so the register restarts empty with no dead cycle.
    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            shreg    <= '0;
            bitCount <= '0;
        end else if (beat) begin
            if (oDone) begin
                shreg    <= '0;
                bitCount <= '0;
            end else begin
                shreg    <= assembled;
                bitCount <= bitCount + CNT_STEP;
            end
        end
    end

endmodule

// File: rtl/deserializer_multilane.sv
// Multilane serial-to-parallel loader with a registered valid/ready output slot
// and a sticky overrun flag for words that arrive while the slot is still full.
module deserializer_multilane
    import deser_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic                            iEn,
    input  logic                            iLoading,
    input  logic                            iClear,
    input  logic [LANES-1:0]                iData_in,
    input  logic                            iReady,
    output logic [DATA_SIZE-1:0]            oData,
    output logic                            oValid,
    output logic [cntWidth(DATA_SIZE)-1:0]  oBit_counter,
    output logic                            oOverrun
);

    if (!geometryOk(DATA_SIZE, LANES)) begin : gBadGeometry
        $error("deserializer_multilane: DATA_SIZE must be a multiple of LANES (1,2,4,8)");
    end

    logic [DATA_SIZE-1:0] coreWord;
    logic                 coreDone;
    outState_t            state;
    outState_t            nextState;
    logic                 loadData;
    logic                 setOverrun;

    deser_shift_core #(
        .DATA_SIZE (DATA_SIZE),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) uCore (
        .iClk         (iClk),
        .iRst         (iRst),
        .iEn          (iEn),
        .iLoading     (iLoading),
        .iClear       (iClear),
        .iData_in     (iData_in),
        .oWord        (coreWord),
        .oDone        (coreDone),
        .oBit_counter (oBit_counter)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= S_EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // A full slot takes a new word only if it is drained on the same edge; otherwise it is dropped.
    always_comb begin
        nextState  = state;
        loadData   = 1'b0;
        setOverrun = 1'b0;
        case (state)
            S_EMPTY: begin
                if (coreDone) begin
                    loadData  = 1'b1;
                    nextState = S_VALID;
                end
            end
            S_VALID: begin
                if (iReady) begin
                    if (coreDone) begin
                        loadData = 1'b1;
                    end else begin
                        nextState = S_EMPTY;
                    end
                end else if (coreDone) begin
                    setOverrun = 1'b1;
                end
            end
            default: begin
                nextState = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData <= '0;
        end else if (loadData) begin
            oData <= coreWord;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oOverrun <= 1'b0;
        end else if (setOverrun) begin
            oOverrun <= 1'b1;
        end
    end

    assign oValid = (state == S_VALID);

endmodule

// File: doc/deserializer_multilane.md
Name: deserializer_multilane

Overview:
- Parametrised successor to the single-bit serial-to-parallel loader in the cipher datapath.
- Accepts LANES bits per enabled cycle and assembles DATA_SIZE-bit words, in MSB-first or LSB-first order.
- Each completed word is presented on a registered valid/ready output stage, so loading can continue while the consumer (the key/plaintext register file) drains the previous word.
- Adds clear, pause, and overrun detection.

Parameters:
- DATA_SIZE, 32, word width in bits; must be a multiple of LANES.
- LANES, 1, bits shifted in per enabled beat; legal values 1, 2, 4, 8.
- MSB_FIRST, 1, 1 = first beat lands in the top bits; 0 = first beat lands in bits [LANES-1:0].

Ports:
- iClk  in  1  clock, all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iEn  in  1  beat qualifier; a beat is consumed only when iEn && iLoading.
- iLoading  in  1  loading mode; low = pause, partial word held.
- iClear  in  1  discard partial word; counter returns to 0.
- iData_in  in  LANES  serial lane data for this beat.
- iReady  in  1  consumer accepts oData when oValid && iReady.
- oData  out  DATA_SIZE  last completed word, registered.
- oValid  out  1  oData holds an unconsumed word.
- oBit_counter  out  $clog2(DATA_SIZE)+1  bits in current partial word.
- oOverrun  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset (iRst=1 at an edge): shift register=0, oBit_counter=0, oData=0, oValid=0, oOverrun=0, output FSM=S_EMPTY. Reset mid-word discards everything.
- Beat = iEn && iLoading && !iClear.
- MSB_FIRST=1: on a beat, shreg <= {shreg[DATA_SIZE-LANES-1:0], iData_in}.
- MSB_FIRST=0: on a beat, iData_in is written into bits [cnt +: LANES] of shreg.
- On a beat, oBit_counter increments by LANES.
- Final beat is the beat when oBit_counter == DATA_SIZE-LANES:
  - Assembled word, including the final beat's lanes, is the completed word.
  - oBit_counter wraps to 0 on the same edge; no dead cycle, so back-to-back words stream at full rate.
- Latency: oValid rises on the edge that samples the final beat; oData is valid in the following cycle.
- Output FSM, S_EMPTY (oValid=0):
  - Word completes -> load oData, go to S_VALID.
- Output FSM, S_VALID (oValid=1):
  - iReady && no completion -> S_EMPTY.
  - iReady && completion -> reload oData, stay in S_VALID. Simultaneous drain+fill is lossless.
  - !iReady && completion -> new word dropped, oData unchanged, oOverrun<=1.
  - !iReady && no completion -> hold.
- oValid equals (state==S_VALID); oData stays stable while oValid && !iReady.
- iLoading=0: no shift; oBit_counter holds the partial count; output stage still handshakes.
- iEn=0 with iLoading=1: no shift; counter holds.
- iClear=1: oBit_counter<=0 and shreg<=0 on that edge, regardless of iEn.
  - iClear does not affect oData, oValid, or oOverrun.
  - iClear on the final-beat cycle wins; no word completes.
- oOverrun clears only on iRst.
- oBit_counter never exceeds DATA_SIZE-LANES when observed.
- Width rule: counter is $clog2(DATA_SIZE)+1 bits; increment is performed at counter width.
- LANES==DATA_SIZE is legal; every beat completes a word.

Decomposition:
- Package deser_pkg holds:
  - output-state enum {S_EMPTY, S_VALID};
  - localparam BEATS_PER_WORD = DATA_SIZE/LANES;
  - localparam CNT_W = $clog2(DATA_SIZE)+1;
  - an elaboration check that flags DATA_SIZE % LANES != 0.
- Sub-module deser_shift_core holds the shift register, counter, clear logic, and done pulse.
- Top level holds the output register, handshake FSM, and overrun flag.

Test Plan:
- DATA_SIZE=8, LANES=2, MSB_FIRST=1, iReady=1.
  - Stimulus: beats 2'b10, 2'b11, 2'b00, 2'b01.
  - Response: after 4th edge oData=8'hB1, oValid=1 for one cycle; oBit_counter sequence 2,4,6,0.
- Same beats with MSB_FIRST=0 -> oData=8'h4E.
- Pause: DATA_SIZE=32, LANES=1, MSB_FIRST=1; shift 16 bits, drop iLoading for 5 cycles, then shift 16 more.
  - Response: oBit_counter holds 16 during the pause; final oData matches the 32-bit sequence, e.g. 32'hDEADBEEF.
- Back-to-back with iReady=0 (DATA_SIZE=8, LANES=8):
  - Beats 8'hA5 then 8'h3C.
  - Response: oData stays 8'hA5, oValid=1, oOverrun=1.
  - Then iReady=1 for one cycle -> oValid=0.
- Simultaneous drain+fill: oValid=1 (oData=8'h11), iReady=1 on the same cycle a beat completes 8'h22.
  - Response: next cycle oData=8'h22, oValid=1, oOverrun=0.
- Clear and reset:
  - Partial word of 3 beats, then iClear=1 with iEn=1 -> oBit_counter=0, no oValid.
  - iRst=1 while oValid=1 -> all outputs 0 next cycle.
